// File: rtl/seq_controller.sv
// Multi-cycle sequencer for a Y86-style core: walks one instruction at a time
// through FETCH..PCUPD, owns the PC, status code and retired-instruction count.
module seq_controller #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [63:0] IMEM_LIMIT = 64'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  icode,
    input  logic        hlt,
    input  logic        mem_error,
    input  logic        instr_valid,
    input  logic        dmem_error,
    input  logic        cnd,
    input  logic [63:0] valP,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    output logic [63:0] PC,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        wb_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT = 4'd0;
    localparam logic [3:0] IC_JXX  = 4'd7;
    localparam logic [3:0] IC_CALL = 4'd8;
    localparam logic [3:0] IC_RET  = 4'd9;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [31:0] count_q, count_d;
    logic        fetch_en_q, decode_en_q, execute_en_q, memory_en_q, wb_en_q;
    logic        busy_q;

    // Fetch fault classification; order of the tests is the priority order.
    function automatic logic [2:0] fetch_status(
        input logic        f_mem_error,
        input logic        f_instr_valid,
        input logic        f_hlt,
        input logic [3:0]  f_icode,
        input logic [63:0] f_pc
    );
        logic [2:0] s;
        if (f_mem_error || (f_pc > IMEM_LIMIT)) begin
            s = STAT_ADR;
        end else if (!f_instr_valid) begin
            s = STAT_INS;
        end else if (f_hlt || (f_icode == IC_HALT)) begin
            s = STAT_HLT;
        end else begin
            s = STAT_AOK;
        end
        return s;
    endfunction

    function automatic logic [63:0] next_pc(
        input logic [3:0]  n_icode,
        input logic        n_cnd,
        input logic [63:0] n_valP,
        input logic [63:0] n_valC,
        input logic [63:0] n_valM
    );
        logic [63:0] p;
        case (n_icode)
            IC_CALL: p = n_valC;
            IC_JXX:  p = n_cnd ? n_valC : n_valP;
            IC_RET:  p = n_valM;
            default: p = n_valP;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_status(mem_error, instr_valid, hlt, icode, pc_q) != STAT_AOK) begin
                    stat_d  = fetch_status(mem_error, instr_valid, hlt, icode, pc_q);
                    state_d = S_HALTED;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (dmem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                pc_d    = next_pc(icode, cnd, valP, valC, valM);
                count_d = count_q + 32'd1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes and busy are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            stat_q       <= STAT_AOK;
            count_q      <= 32'd0;
            fetch_en_q   <= 1'b0;
            decode_en_q  <= 1'b0;
            execute_en_q <= 1'b0;
            memory_en_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stat_q       <= stat_d;
            count_q      <= count_d;
            fetch_en_q   <= (state_d == S_FETCH);
            decode_en_q  <= (state_d == S_DECODE);
            execute_en_q <= (state_d == S_EXECUTE);
            memory_en_q  <= (state_d == S_MEMORY);
            wb_en_q      <= (state_d == S_WRITEBACK);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_HALTED);
        end
    end

    assign PC          = pc_q;
    assign stat        = stat_q;
    assign instr_count = count_q;
    assign fetch_en    = fetch_en_q;
    assign decode_en   = decode_en_q;
    assign execute_en  = execute_en_q;
    assign memory_en   = memory_en_q;
    assign wb_en       = wb_en_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seq_controller.sv
// Randomized bench for seq_controller: each instruction is judged against an
// instruction-level model (stage list, halt status, next PC, retire count).
module tb_seq_controller;

    localparam logic [63:0] RST_PC = 64'd0;
    localparam logic [63:0] LIMIT  = 64'd1023;

    localparam logic [4:0] ST_F = 5'b10000;
    localparam logic [4:0] ST_D = 5'b01000;
    localparam logic [4:0] ST_E = 5'b00100;
    localparam logic [4:0] ST_M = 5'b00010;
    localparam logic [4:0] ST_W = 5'b00001;
    localparam logic [4:0] ST_0 = 5'b00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  icode = 4'd1;
    logic        hlt = 1'b0, mem_error = 1'b0, instr_valid = 1'b1, dmem_error = 1'b0, cnd = 1'b0;
    logic [63:0] valP = '0, valC = '0, valM = '0;
    logic [63:0] PC;
    logic        fetch_en, decode_en, execute_en, memory_en, wb_en, busy;
    logic [2:0]  stat;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic [2:0]  m_stat;
    bit          m_halted;

    typedef struct {
        logic [3:0]  icode;
        logic        hlt, mem_error, instr_valid, dmem, cnd;
        logic [63:0] valP, valC, valM;
    } instr_t;

    seq_controller #(.RESET_PC(RST_PC), .IMEM_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .icode(icode), .hlt(hlt),
        .mem_error(mem_error), .instr_valid(instr_valid), .dmem_error(dmem_error),
        .cnd(cnd), .valP(valP), .valC(valC), .valM(valM), .PC(PC),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .wb_en(wb_en), .stat(stat), .busy(busy),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] strb();
        return {fetch_en, decode_en, execute_en, memory_en, wb_en};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic instr_t mk(input logic [3:0] ic, input logic [63:0] p,
                                  input logic [63:0] c, input logic [63:0] m, input logic cd);
        instr_t t;
        t.icode = ic; t.hlt = 1'b0; t.mem_error = 1'b0; t.instr_valid = 1'b1;
        t.dmem = 1'b0; t.cnd = cd; t.valP = p; t.valC = c; t.valM = m;
        return t;
    endfunction

    // Instruction-level view of the rules: 0 means the fetch is clean.
    function automatic logic [2:0] model_fetch(input instr_t t, input logic [63:0] pc);
        if (t.mem_error || pc > LIMIT) return 3'd3;
        if (!t.instr_valid)            return 3'd4;
        if (t.hlt || t.icode == 4'd0)  return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [63:0] model_next(input instr_t t);
        if (t.icode == 4'd8) return t.valC;
        if (t.icode == 4'd7) return t.cnd ? t.valC : t.valP;
        if (t.icode == 4'd9) return t.valM;
        return t.valP;
    endfunction

    task automatic scramble_ops();
        cnd = 1'($urandom); valP = rnd64(); valC = rnd64(); valM = rnd64();
    endtask

    task automatic check_halted();
        check("halt_strb", strb(), ST_0);
        check("halt_busy", busy, 0);
        check("halt_stat", stat, m_stat);
        check("halt_pc", PC, m_pc);
        check("halt_cnt", instr_count, m_cnt);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            hlt = 1'($urandom); mem_error = 1'($urandom); instr_valid = 1'($urandom);
            dmem_error = 1'($urandom); icode = 4'($urandom); scramble_ops();
            @(negedge clk);
        end
        check("halt_hold_strb", strb(), ST_0);
        check("halt_hold_busy", busy, 0);
        check("halt_hold_stat", stat, m_stat);
        check("halt_hold_pc", PC, m_pc);
        check("halt_hold_cnt", instr_count, m_cnt);
    endtask

    // Pulls reset at a negedge, checks it acts at once, and leaves the DUT in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", PC, RST_PC);
        check("rst_cnt", instr_count, 0);
        check("rst_stat", stat, 1);
        check("rst_strb", strb(), ST_0);
        check("rst_busy", busy, 0);
        m_pc = RST_PC; m_cnt = 0; m_stat = 3'd1; m_halted = 0;
        @(negedge clk);
        hlt = 0; mem_error = 0; instr_valid = 1; dmem_error = 0;
        rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT expected in FETCH.
    task automatic do_instr(input instr_t t, input bit pause, input bit rst_in_exec);
        logic [2:0] f;
        check("fetch_strb", strb(), ST_F);
        check("fetch_busy", busy, 1);
        check("fetch_pc", PC, m_pc);
        check("fetch_cnt", instr_count, m_cnt);
        check("fetch_stat", stat, 1);
        icode = t.icode; hlt = t.hlt; mem_error = t.mem_error; instr_valid = t.instr_valid;
        dmem_error = 1'($urandom);
        scramble_ops();
        f = model_fetch(t, m_pc);
        @(negedge clk);
        if (f != 3'd0) begin
            m_stat = f; m_halted = 1;
            check_halted();
            return;
        end
        check("dec_strb", strb(), ST_D);
        hlt = 1'($urandom); mem_error = 1'($urandom); instr_valid = 1'($urandom);
        if (pause) run = 1'b0;
        @(negedge clk);
        check("exe_strb", strb(), ST_E);
        if (rst_in_exec) begin
            check("exe_cnt_pre_rst", instr_count, m_cnt);
            do_reset();
            return;
        end
        @(negedge clk);
        check("mem_strb", strb(), ST_M);
        dmem_error = t.dmem;
        @(negedge clk);
        if (t.dmem) begin
            m_stat = 3'd3; m_halted = 1;
            check_halted();
            return;
        end
        check("wb_strb", strb(), ST_W);
        dmem_error = 1'($urandom);
        cnd = t.cnd; valP = t.valP; valC = t.valC; valM = t.valM;
        @(negedge clk);
        check("pcu_strb", strb(), ST_0);
        check("pcu_busy", busy, 1);
        check("pcu_pc_old", PC, m_pc);
        m_pc  = model_next(t);
        m_cnt = m_cnt + 32'd1;
        @(negedge clk);
        check("ret_pc", PC, m_pc);
        check("ret_cnt", instr_count, m_cnt);
        scramble_ops();
        icode = 4'($urandom);
        if (pause) begin
            for (int i = 0; i < 3; i++) begin
                check("idle_strb", strb(), ST_0);
                check("idle_busy", busy, 0);
                check("idle_pc", PC, m_pc);
                @(negedge clk);
            end
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        instr_t t;
        m_pc = RST_PC; m_cnt = 0; m_stat = 3'd1; m_halted = 0;
        @(negedge clk);
        check("init_pc", PC, RST_PC);
        check("init_strb", strb(), ST_0);
        check("init_busy", busy, 0);
        check("init_stat", stat, 1);
        check("init_cnt", instr_count, 0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_norun_strb", strb(), ST_0);
            check("idle_norun_busy", busy, 0);
        end
        run = 1'b1;
        @(negedge clk);

        do_instr(mk(4'd1, 64'h1, 64'h0, 64'h0, 1'b0), 0, 0);
        do_instr(mk(4'd7, 64'h09, 64'h40, 64'h0, 1'b1), 0, 0);
        check("jxx_taken", PC, 64'h40);
        do_instr(mk(4'd7, 64'h09, 64'h40, 64'h0, 1'b0), 0, 0);
        check("jxx_not_taken", PC, 64'h09);
        do_instr(mk(4'd8, 64'h0a, 64'h25, 64'h0, 1'b0), 0, 0);
        check("call_pc", PC, 64'h25);
        do_instr(mk(4'd9, 64'h26, 64'h0, 64'h26, 1'b0), 0, 0);
        check("ret_pc_dir", PC, 64'h26);
        check("count_five", instr_count, 5);
        do_instr(mk(4'd1, 64'h99, 64'h0, 64'h0, 1'b0), 0, 1);
        do_instr(mk(4'd1, 64'h27, 64'h0, 64'h0, 1'b0), 0, 0);

        t = mk(4'd1, 64'h28, 64'h0, 64'h0, 1'b0); t.hlt = 1'b1;
        do_instr(t, 0, 0);
        check("hlt_stat", stat, 2);
        check("hlt_pc", PC, 64'h27);
        do_reset();

        t = mk(4'd1, 64'h1, 64'h0, 64'h0, 1'b0); t.mem_error = 1'b1; t.instr_valid = 1'b0; t.hlt = 1'b1;
        do_instr(t, 0, 0);
        check("prio_adr", stat, 3);
        do_reset();
        t = mk(4'd0, 64'h1, 64'h0, 64'h0, 1'b0); t.instr_valid = 1'b0;
        do_instr(t, 0, 0);
        check("prio_ins", stat, 4);
        do_reset();
        t = mk(4'd1, 64'h1, 64'h0, 64'h0, 1'b0); t.dmem = 1'b1;
        do_instr(t, 0, 0);
        check("dmem_adr", stat, 3);
        do_reset();

        do_instr(mk(4'd3, 64'h0a, 64'h0, 64'h0, 1'b0), 1, 0);
        do_instr(mk(4'd8, 64'h14, 64'd1023, 64'h0, 1'b0), 0, 0);
        do_instr(mk(4'd1, 64'd1024, 64'h0, 64'h0, 1'b0), 0, 0);
        do_instr(mk(4'd1, 64'h2, 64'h0, 64'h0, 1'b0), 0, 0);
        check("limit_adr", stat, 3);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            t.icode = 4'($urandom_range(0, 11));
            t.hlt = ($urandom_range(0, 24) == 0);
            t.mem_error = ($urandom_range(0, 24) == 0);
            t.instr_valid = ($urandom_range(0, 24) != 0);
            t.dmem = ($urandom_range(0, 24) == 0);
            t.cnd = 1'($urandom);
            t.valP = ($urandom_range(0, 9) == 0) ? rnd64() : 64'($urandom_range(0, 1100));
            t.valC = ($urandom_range(0, 9) == 0) ? rnd64() : 64'($urandom_range(0, 1100));
            t.valM = ($urandom_range(0, 9) == 0) ? rnd64() : 64'($urandom_range(0, 1100));
            if (t.icode == 4'd0 && $urandom_range(0, 1) == 0) t.icode = 4'd6;
            do_instr(t, ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
            if (m_halted) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
